// File: rtl/pipeline_register.sv
// ---------------------------------------------------------------------------
// pipeline_register
// Two-entry skid-buffer pipeline stage for the CPU datapath (IF/ID, ID/EX,
// EX/MEM, MEM/WB). It sustains one word per cycle with one cycle of latency.
// in_ready comes straight from a flop, so downstream back-pressure never
// forms a combinational path back across the stage. A synchronous flush
// squashes every held entry when a branch or exception is taken.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous squash of all held entries
//   in_valid   upstream word present
//   in_ready   stage can accept a word (flop)
//   in_data    upstream payload, WIDTH bits
//   out_valid  stage presents a word (flop)
//   out_ready  downstream accepts the word
//   out_data   payload presented downstream (flop)
//   level      number of held entries, 0..2 (flop)
// ---------------------------------------------------------------------------
module pipeline_register #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       level
);

   // Main register holds the head word; skid holds the one extra word that
   // arrives during the cycle back-pressure starts.
   logic             main_v_r;
   logic             skid_v_r;
   logic [WIDTH-1:0] main_d_r;
   logic [WIDTH-1:0] skid_d_r;
   logic             in_ready_r;
   logic [1:0]       level_r;

   logic             main_v_s;
   logic             skid_v_s;
   logic [WIDTH-1:0] main_d_s;
   logic [WIDTH-1:0] skid_d_s;
   logic             it_s;
   logic             ot_s;

   // in_ready_r always mirrors !skid_v_r, so using it here keeps the
   // acceptance decision on the same flop the upstream stage sees.
   assign it_s = in_valid & in_ready_r;
   assign ot_s = main_v_r & out_ready;

   // Next-state decode for the EMPTY / ONE / TWO occupancy states.
   always_comb begin
      main_v_s = main_v_r;
      skid_v_s = skid_v_r;
      main_d_s = main_d_r;
      skid_d_s = skid_d_r;
      if (flush) begin
         // An output transfer this cycle has already been sampled downstream
         // and an input transfer is discarded, so both simply vanish.
         main_v_s = 1'b0;
         skid_v_s = 1'b0;
      end else begin
         case ({main_v_r, skid_v_r})
            2'b00: begin
               if (it_s) begin
                  main_v_s = 1'b1;
                  main_d_s = in_data;
               end else begin
                  main_v_s = 1'b0;
               end
            end
            2'b10: begin
               if (it_s && ot_s) begin
                  main_d_s = in_data;
               end else if (it_s) begin
                  skid_v_s = 1'b1;
                  skid_d_s = in_data;
               end else if (ot_s) begin
                  main_v_s = 1'b0;
               end else begin
                  main_v_s = 1'b1;
               end
            end
            2'b11: begin
               if (ot_s) begin
                  main_d_s = skid_d_r;
                  skid_v_s = 1'b0;
               end else begin
                  skid_v_s = 1'b1;
               end
            end
            default: begin
               // Skid without main cannot occur; recover to EMPTY.
               main_v_s = 1'b0;
               skid_v_s = 1'b0;
            end
         endcase
      end
   end

   // State and output flops; in_ready and level are registered from the
   // next-state values so every output leaves the block on a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v_r   <= 1'b0;
         skid_v_r   <= 1'b0;
         main_d_r   <= RESET_VALUE;
         skid_d_r   <= RESET_VALUE;
         in_ready_r <= 1'b1;
         level_r    <= 2'd0;
      end else begin
         main_v_r   <= main_v_s;
         skid_v_r   <= skid_v_s;
         main_d_r   <= main_d_s;
         skid_d_r   <= skid_d_s;
         in_ready_r <= ~skid_v_s;
         level_r    <= {1'b0, main_v_s} + {1'b0, skid_v_s};
      end
   end

   assign out_valid = main_v_r;
   assign out_data  = main_d_r;
   assign in_ready  = in_ready_r;
   assign level     = level_r;

endmodule

// File: tb/tb_pipeline_register.sv
// ---------------------------------------------------------------------------
// tb_pipeline_register
// Directed and random checks of pipeline_register at WIDTH 32, 1 and 64.
// The three instances share handshake and flush controls; each has its own
// payload so data integrity is checked at every width.
// ---------------------------------------------------------------------------
module tb_pipeline_register;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;

   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [1:0]  level;

   logic        in_data1;
   logic        in_ready1;
   logic        out_valid1;
   logic        out_data1;
   logic [1:0]  level1;

   logic [63:0] in_data64;
   logic        in_ready64;
   logic        out_valid64;
   logic [63:0] out_data64;
   logic [1:0]  level64;

   int n_cmp;
   int n_err;

   logic [63:0] pat64 [8];
   logic [31:0] q [$];

   pipeline_register #(.WIDTH(32), .RESET_VALUE(32'hDEADBEEF)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level)
   );

   pipeline_register #(.WIDTH(1), .RESET_VALUE(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data1),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .level(level1)
   );

   pipeline_register #(.WIDTH(64), .RESET_VALUE(64'h0123456789ABCDEF)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64), .in_data(in_data64),
      .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64),
      .level(level64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Handshake status of the 32-bit instance.
   task automatic check_hs(input string tag, input logic ov, input logic ir, input logic [1:0] lv);
      check({tag, "_out_valid"}, {63'd0, out_valid}, {63'd0, ov});
      check({tag, "_in_ready"},  {63'd0, in_ready},  {63'd0, ir});
      check({tag, "_level"},     {62'd0, level},     {62'd0, lv});
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = 32'd0;
      in_data1  = 1'b0;
      in_data64 = 64'd0;
      pat64[0] = 64'hFFFFFFFFFFFFFFFF;
      pat64[1] = 64'hA5A5A5A5A5A5A5A5;
      pat64[2] = 64'h5A5A5A5A5A5A5A5A;
      pat64[3] = 64'h0000000000000000;
      pat64[4] = 64'hFFFFFFFF00000000;
      pat64[5] = 64'hA5A5A5A5FFFFFFFF;
      pat64[6] = 64'h8000000000000001;
      pat64[7] = 64'hFFFFFFFFFFFFFFFF;

      // Reset state at power-up.
      @(negedge clk);
      check_hs("por", 1'b0, 1'b1, 2'd0);
      check("por_data", {32'd0, out_data}, 64'h00000000DEADBEEF);
      check("por_data64", out_data64, 64'h0123456789ABCDEF);
      check("por_data1", {63'd0, out_data1}, 64'd1);

      // Fill to level 2, then pull reset asynchronously mid-cycle.
      rst_n     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h11;
      out_ready = 1'b0;
      @(negedge clk);
      in_data = 32'h22;
      @(negedge clk);
      check_hs("fill2", 1'b1, 1'b0, 2'd2);
      #2 rst_n = 1'b0;
      #1;
      check_hs("rst_mid", 1'b0, 1'b1, 2'd0);
      check("rst_mid_data", {32'd0, out_data}, 64'h00000000DEADBEEF);
      check("rst_mid_data64", out_data64, 64'h0123456789ABCDEF);
      in_valid = 1'b0;
      @(negedge clk);
      check_hs("rst_hold", 1'b0, 1'b1, 2'd0);
      rst_n = 1'b1;

      // Streaming 1..8 at full throughput on all three widths.
      out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         in_valid  = 1'b1;
         in_data   = 32'(k);
         in_data1  = k[0];
         in_data64 = pat64[k-1];
         @(negedge clk);
         check_hs($sformatf("str%0d", k), 1'b1, 1'b1, 2'd1);
         check($sformatf("str%0d_data", k), {32'd0, out_data}, 64'(k));
         check($sformatf("str%0d_data1", k), {63'd0, out_data1}, {63'd0, k[0]});
         check($sformatf("str%0d_data64", k), out_data64, pat64[k-1]);
         check($sformatf("str%0d_ir1", k), {63'd0, in_ready1}, 64'd1);
         check($sformatf("str%0d_ir64", k), {63'd0, in_ready64}, 64'd1);
         check($sformatf("str%0d_lv1", k), {62'd0, level1}, 64'd1);
         check($sformatf("str%0d_lv64", k), {62'd0, level64}, 64'd1);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check_hs("str_drain", 1'b0, 1'b1, 2'd0);
      check("str_drain_ov64", {63'd0, out_valid64}, 64'd0);

      // Skid fill: ONE with 0xA, back-pressure while 0xB arrives.
      in_valid  = 1'b1;
      in_data   = 32'hA;
      out_ready = 1'b0;
      @(negedge clk);
      check_hs("sk_one", 1'b1, 1'b1, 2'd1);
      check("sk_one_data", {32'd0, out_data}, 64'hA);
      in_data = 32'hB;
      @(negedge clk);
      check_hs("sk_two", 1'b1, 1'b0, 2'd2);
      check("sk_two_data", {32'd0, out_data}, 64'hA);
      in_data = 32'hC;
      @(negedge clk);
      check_hs("sk_hold", 1'b1, 1'b0, 2'd2);
      check("sk_hold_data", {32'd0, out_data}, 64'hA);
      out_ready = 1'b1;
      @(negedge clk);
      check_hs("sk_dr1", 1'b1, 1'b1, 2'd1);
      check("sk_dr1_data", {32'd0, out_data}, 64'hB);
      @(negedge clk);
      check_hs("sk_dr2", 1'b1, 1'b1, 2'd1);
      check("sk_dr2_data", {32'd0, out_data}, 64'hC);
      in_valid = 1'b0;
      @(negedge clk);
      check_hs("sk_empty", 1'b0, 1'b1, 2'd0);

      // Flush in TWO with a word offered and the head being taken.
      in_valid  = 1'b1;
      in_data   = 32'h10;
      out_ready = 1'b0;
      @(negedge clk);
      in_data = 32'h11;
      @(negedge clk);
      check_hs("fl_two", 1'b1, 1'b0, 2'd2);
      check("fl_two_data", {32'd0, out_data}, 64'h10);
      in_data   = 32'hE;
      out_ready = 1'b1;
      flush     = 1'b1;
      @(negedge clk);
      check_hs("fl_after", 1'b0, 1'b1, 2'd0);
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_hs("fl_after2", 1'b0, 1'b1, 2'd0);

      // Flush in ONE discards the word accepted in the same cycle.
      in_valid  = 1'b1;
      in_data   = 32'h20;
      out_ready = 1'b0;
      @(negedge clk);
      in_data = 32'h21;
      flush   = 1'b1;
      @(negedge clk);
      check_hs("fl_one", 1'b0, 1'b1, 2'd0);
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_hs("fl_one2", 1'b0, 1'b1, 2'd0);

      // Random handshake and flush against a scoreboard queue.
      q.delete();
      for (int c = 0; c < 10000; c++) begin
         logic it;
         logic ot;
         check("rnd_level", {62'd0, level}, 64'(q.size()));
         check("rnd_out_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0)});
         check("rnd_in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
         if (q.size() > 0) begin
            check("rnd_data", {32'd0, out_data}, {32'd0, q[0]});
         end
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 99) < 2);
         in_data   = $urandom;
         in_data1  = in_data[0];
         in_data64 = {in_data, ~in_data};
         it = in_valid && (q.size() < 2);
         ot = out_ready && (q.size() > 0);
         if (ot) begin
            void'(q.pop_front());
         end
         if (flush) begin
            q.delete();
         end else if (it) begin
            q.push_back(in_data);
         end
         @(negedge clk);
      end
      check("rnd_final_level", {62'd0, level}, 64'(q.size()));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_register.md
# pipeline_register

Parametrised, clocked pipeline-stage register for the CPU datapath with a valid/ready handshake on both sides. It is a two-entry skid buffer: full throughput of one word per cycle, one cycle of latency, and a fully registered `in_ready` so back-pressure never forms a combinational path across a stage. It sits between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and supports a synchronous flush for branch and exception squashing.

## Interface
- `WIDTH`, 32, payload width in bits.
- `RESET_VALUE`, 0, value loaded into both data registers on reset (`WIDTH` bits).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  stage can accept a word; driven directly from a flop.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  stage presents a word.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  WIDTH  payload presented downstream.
- `level`  out  2  number of held entries (0, 1 or 2).

## Operation
- Storage: main register (`main_v`, `main_d`) and skid register (`skid_v`, `skid_d`).
- Output mapping: `out_valid = main_v`, `out_data = main_d`, `in_ready = !skid_v`, `level = main_v + skid_v`.
- Transfers:
  - An input transfer (IT) occurs when `in_valid && in_ready`.
  - An output transfer (OT) occurs when `out_valid && out_ready`.
- States and transitions (no flush):
  - EMPTY (0 entries):
    - IT → `main_d <= in_data`, go to ONE.
  - ONE (main only):
    - IT and OT → `main_d <= in_data`, stay in ONE.
    - IT only → `skid_d <= in_data`, go to TWO.
    - OT only → go to EMPTY.
    - Neither → hold.
  - TWO (main and skid): `in_ready` is 0, so no IT is possible.
    - OT → `main_d <= skid_d`, clear `skid_v`, go to ONE.
    - No OT → hold.
- Ordering: words leave in acceptance order. No word is ever dropped or duplicated unless flushed.
- Data registers change only on the loads listed above; otherwise they hold. Contents behind a cleared valid are don't-care.
- `flush = 1` at an edge:
  - Both valids clear and the state goes to EMPTY.
  - An IT in the same cycle is discarded.
  - An OT in the same cycle counts as completed, because downstream sampled it.
  - Flush overrides every other transition.
- Reset (`rst_n` low, at any time, including in the middle of a transfer):
  - `main_v = skid_v = 0`, `main_d = skid_d = RESET_VALUE`.
  - Outputs during reset: `out_valid = 0`, `in_ready = 1`, `level = 0`, `out_data = RESET_VALUE`.
  - After release the block behaves as EMPTY on the first rising edge.

## Timing
- Latency: a word accepted at edge N is visible on `out_data`/`out_valid` after edge N and can leave at edge N+1 at the earliest.
- Throughput: one word per cycle while `out_ready` stays high. The skid register is never used in that case.
- `in_ready` falls only on the edge that fills the skid register. It rises on the edge that drains the skid register, or on a flush.
- Every output is a flop or a decode of flops. There is no combinational path from `out_ready` or `in_valid` to `in_ready`.
- Back-pressure that starts while `in_valid` is high absorbs exactly one extra word (into skid) before `in_ready` drops.

## Test plan
- Reset: assert `rst_n=0` mid-stream with `level=2` and `RESET_VALUE=32'hDEADBEEF`. Required while low: `out_valid=0`, `in_ready=1`, `level=0`, `out_data=32'hDEADBEEF`.
- Streaming: send 0x1..0x8 on consecutive cycles with `out_ready=1`. Required: 0x1..0x8 appear in order, one cycle after each is accepted; `in_ready` stays 1 and `level` stays ≤1.
- Skid fill: with ONE holding 0xA, drop `out_ready` and present 0xB. Required: skid gets 0xB, `level=2`, `in_ready=0` next cycle, 0xC is held off. Then raise `out_ready`. Required: 0xA, 0xB, 0xC delivered in order with no gap once draining begins.
- Flush in TWO with `in_valid=1` (0xE) and `out_ready=1`. Required: the head word counts as delivered, 0xE is not stored, next cycle `out_valid=0`, `level=0`, `in_ready=1`.
- Random valid/ready over 10k cycles, with flushes at 2% probability, against a scoreboard queue. Required: no loss, duplication or reordering except the entries a flush removes, and `level` always equals the scoreboard depth.
- Parameterisation: repeat streaming at `WIDTH=1` and `WIDTH=64`. Required: identical handshake behaviour and full-width data integrity (patterns all-ones and 0xA5…).
